pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard, stall and flush controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB). It fills the pipeline's controller slot.
- Produces per-stage write-enables and flushes, plus EX operand forwarding selects.
- Sequences data-memory wait states with a timeout.
- Keeps stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 32, performance counter width
- MEM_TIMEOUT, 16, maximum consecutive MEM wait cycles before error/release

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- id_rs1  in  REG_AW  rs1 of instruction in ID
- id_rs2  in  REG_AW  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  REG_AW  destination in ID/EX
- id_ex_is_load  in  1  ID/EX holds a load
- ex_rs1  in  REG_AW  rs1 of the instruction in EX
- ex_rs2  in  REG_AW  rs2 of the instruction in EX
- ex_mem_rd  in  REG_AW  destination in EX/MEM
- ex_mem_regwrite  in  1  EX/MEM writes the register file
- ex_mem_is_branch  in  1  taken branch resolved, in EX/MEM
- ex_mem_mem_req  in  1  EX/MEM performs a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- mem_wb_rd  in  REG_AW  destination in MEM/WB
- mem_wb_regwrite  in  1  MEM/WB writes the register file
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID register enable
- id_ex_we  out  1  ID/EX register enable
- ex_mem_we  out  1  EX/MEM register enable
- mem_wb_we  out  1  MEM/WB register enable
- if_id_flush  out  1  load a bubble into IF/ID
- id_ex_flush  out  1  load a bubble into ID/EX
- ex_mem_flush  out  1  load a bubble into EX/MEM
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- mem_err  out  1  sticky flag: a memory access timed out
- stall_cycles  out  CNT_W  count of cycles with pc_we=0
- flush_count  out  CNT_W  count of branch flush events

Behaviour:
- State register (async clear to RUN): RUN, FLUSH, MEM_WAIT. The wait counter wcnt is log2(MEM_TIMEOUT)+1 bits.
- Reset (rst=0): state=RUN, wcnt=0, mem_err=0, stall_cycles=0, flush_count=0.
- With idle inputs after reset: all *_we=1, all flushes=0, fwd_a=fwd_b=00.
- All enable, flush and fwd outputs are combinational from state and inputs. Registers and counters update on posedge clk.

Priority in RUN, highest first:
1. MEM wait: ex_mem_mem_req=1 and mem_ready=0.
   - All five *_we=0, no flushes.
   - Next state MEM_WAIT, wcnt<=1.
2. Branch: ex_mem_is_branch=1.
   - if_id_flush, id_ex_flush and ex_mem_flush all =1; all *_we=1.
   - flush_count+1. Next state FLUSH.
3. Load-use hazard: id_ex_is_load=1, id_ex_rd!=0, and (id_use_rs1 and id_rs1==id_ex_rd, or id_use_rs2 and id_rs2==id_ex_rd).
   - pc_we=0, if_id_we=0, id_ex_flush=1.
   - Stay in RUN; the hazard clears the following cycle.
4. Otherwise: all *_we=1, no flushes.

FLUSH (exactly 1 cycle):
- ex_mem_is_branch is ignored, since EX/MEM now holds a bubble.
- Load-use detection still applies.
- Next state RUN.

MEM_WAIT:
- All *_we=0.
- If mem_ready=1: enables go to 1 this cycle, wcnt<=0, next state RUN.
- Else if wcnt==MEM_TIMEOUT: mem_err<=1 (sticky until reset), enables go to 1 (the access is dropped), next state RUN.
- Else: wcnt+1.

Forwarding, per operand (X = ex_rs1 for fwd_a, ex_rs2 for fwd_b):
- 10 if ex_mem_regwrite and ex_mem_rd!=0 and ex_mem_rd==X.
- Else 01 if mem_wb_regwrite and mem_wb_rd!=0 and mem_wb_rd==X.
- Else 00.
- Register x0 is never forwarded.

Counters:
- stall_cycles increments every cycle pc_we=0.
- Both counters wrap modulo 2^CNT_W.

Boundary cases:
- Branch and load-use in the same cycle: the flush wins; no load-use stall.
- mem_ready=1 on the first request cycle: no stall.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared.

Decomposition:
- Shared package holds:
  - state encoding RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - RISC-V opcode constants: LOAD=7'b0000011, STORE=7'b0100011, BRANCH=7'b1100011
- Sub-module fwd_unit: purely combinational forwarding selects, instantiated once per operand.

Test Plan:
- Forwarding: ex_mem_rd=5 with regwrite=1, mem_wb_rd=5 with regwrite=1, ex_rs1=5 -> fwd_a=10. Same with ex_mem_regwrite=0 -> fwd_a=01. Same with rd=0 -> fwd_a=00.
- Load-use: id_ex_is_load=1, id_ex_rd=7, id_rs2=7, id_use_rs2=1 -> pc_we=0, if_id_we=0, id_ex_flush=1 for 1 cycle, stall_cycles=1.
- Branch: ex_mem_is_branch=1 held 2 cycles -> 3 flushes high in cycle 1 only, flush_count=1, state FLUSH then RUN.
- Mem wait: mem_req=1, mem_ready low 3 cycles then high -> all *_we=0 for 3 cycles, released on the 4th, stall_cycles=3, mem_err=0.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=16 -> release after 17 cycles, mem_err=1 and stays 1 until rst=0.
- Reset mid-wait: rst=0 during MEM_WAIT -> state RUN, counters 0, mem_err=0, all *_we=1 with idle inputs.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1, id_rs2, id_ex_rd, ex_rs1, ex_rs2, ex_mem_rd, mem_wb_rd;
    logic              id_use_rs1, id_use_rs2, id_ex_is_load;
    logic              ex_mem_regwrite, ex_mem_is_branch, ex_mem_mem_req, mem_ready;
    logic              mem_wb_regwrite;
    logic              pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic              if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cycles, flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_is_load,
               ex_rs1, ex_rs2, ex_mem_rd, ex_mem_regwrite, ex_mem_is_branch,
               ex_mem_mem_req, mem_ready, mem_wb_rd, mem_wb_regwrite,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
               mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_is_load,
               ex_rs1, ex_rs2, ex_mem_rd, ex_mem_regwrite, ex_mem_is_branch,
               ex_mem_mem_req, mem_ready, mem_wb_rd, mem_wb_regwrite,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
               mem_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one operand; EX/MEM beats MEM/WB, x0 never forwarded.
module fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output fwd_sel_t          fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller: stage enables, flushes, forwarding, MEM wait timeout, perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    logic mem_stall, load_use, timeout, hold_all, flush_all, lu_stall;

    assign mem_stall = bus.ex_mem_mem_req && !bus.mem_ready;
    assign load_use  = bus.id_ex_is_load && (bus.id_ex_rd != '0) &&
                       ((bus.id_use_rs1 && (bus.id_rs1 == bus.id_ex_rd)) ||
                        (bus.id_use_rs2 && (bus.id_rs2 == bus.id_ex_rd)));
    assign timeout   = (wcnt_q == WCNT_W'(MEM_TIMEOUT));

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            wcnt_q         <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        hold_all  = 1'b0;
        flush_all = 1'b0;
        lu_stall  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall)                 hold_all  = 1'b1;
                else if (bus.ex_mem_is_branch) flush_all = 1'b1;
                else if (load_use)             lu_stall  = 1'b1;
            end
            // EX/MEM holds the bubble of the branch flush, so only load-use matters here.
            ST_FLUSH:    lu_stall = load_use;
            ST_MEM_WAIT: hold_all = !bus.mem_ready && !timeout;
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        mem_err_d      = mem_err_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end else if (bus.ex_mem_is_branch) begin
                    state_d       = ST_FLUSH;
                    flush_count_d = flush_count_q + 1'b1;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (timeout) begin
                    state_d   = ST_RUN;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (hold_all || lu_stall) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    assign bus.pc_we        = !(hold_all || lu_stall);
    assign bus.if_id_we     = !(hold_all || lu_stall);
    assign bus.id_ex_we     = !hold_all;
    assign bus.ex_mem_we    = !hold_all;
    assign bus.mem_wb_we    = !hold_all;
    assign bus.if_id_flush  = flush_all;
    assign bus.id_ex_flush  = flush_all || lu_stall;
    assign bus.ex_mem_flush = flush_all;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs           (bus.ex_rs1),
        .ex_mem_rd       (bus.ex_mem_rd),
        .ex_mem_regwrite (bus.ex_mem_regwrite),
        .mem_wb_rd       (bus.mem_wb_rd),
        .mem_wb_regwrite (bus.mem_wb_regwrite),
        .fwd_sel         (bus.fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs           (bus.ex_rs2),
        .ex_mem_rd       (bus.ex_mem_rd),
        .ex_mem_regwrite (bus.ex_mem_regwrite),
        .mem_wb_rd       (bus.mem_wb_rd),
        .mem_wb_regwrite (bus.mem_wb_regwrite),
        .fwd_sel         (bus.fwd_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, branch flush, MEM wait/timeout, reset.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n_stall;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_ex_rd = '0; bus.id_ex_is_load = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_mem_rd = '0; bus.ex_mem_regwrite = 1'b0;
        bus.ex_mem_is_branch = 1'b0; bus.ex_mem_mem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.mem_wb_rd = '0; bus.mem_wb_regwrite = 1'b0;
    endtask

    function automatic logic [4:0] we_vec();
        return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
    endfunction

    function automatic logic [2:0] fl_vec();
        return {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
    endfunction

    initial begin
        idle();
        #1;
        check("rst_we",      64'(we_vec()), 64'h1f);
        check("rst_flush",   64'(fl_vec()), 64'h0);
        check("rst_fwd",     64'({bus.fwd_a, bus.fwd_b}), 64'h0);
        check("rst_err",     64'(bus.mem_err), 64'h0);
        check("rst_stall",   64'(bus.stall_cycles), 64'h0);
        check("rst_flushcnt", 64'(bus.flush_count), 64'h0);
        #11 rst = 1'b1;
        tick();

        // Forwarding
        bus.ex_mem_rd = 5'd5; bus.ex_mem_regwrite = 1'b1;
        bus.mem_wb_rd = 5'd5; bus.mem_wb_regwrite = 1'b1;
        bus.ex_rs1 = 5'd5; bus.ex_rs2 = 5'd3;
        #1;
        check("fwd_a_mem", 64'(bus.fwd_a), 64'h2);
        check("fwd_b_none", 64'(bus.fwd_b), 64'h0);
        bus.ex_mem_regwrite = 1'b0;
        #1;
        check("fwd_a_wb", 64'(bus.fwd_a), 64'h1);
        bus.ex_mem_regwrite = 1'b1; bus.ex_rs2 = 5'd9; bus.mem_wb_rd = 5'd9;
        #1;
        check("fwd_b_wb", 64'(bus.fwd_b), 64'h1);
        bus.ex_mem_rd = 5'd0; bus.mem_wb_rd = 5'd0; bus.ex_rs1 = 5'd0;
        #1;
        check("fwd_a_x0", 64'(bus.fwd_a), 64'h0);
        idle();

        // Load-use
        tick();
        bus.id_ex_is_load = 1'b1; bus.id_ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b0;
        #1;
        check("lu_unused_we", 64'(we_vec()), 64'h1f);
        bus.id_ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1'b1;
        #1;
        check("lu_x0_we", 64'(we_vec()), 64'h1f);
        bus.id_ex_rd = 5'd7; bus.id_rs2 = 5'd7;
        #1;
        check("lu_we", 64'(we_vec()), 64'h07);
        check("lu_flush", 64'(fl_vec()), 64'h2);
        tick();
        idle();
        #1;
        check("lu_stall_cnt", 64'(bus.stall_cycles), 64'd1);
        check("lu_clear_we", 64'(we_vec()), 64'h1f);

        // Branch held two cycles
        bus.ex_mem_is_branch = 1'b1;
        #1;
        check("br_flush1", 64'(fl_vec()), 64'h7);
        check("br_we1", 64'(we_vec()), 64'h1f);
        tick();
        check("br_state_flush", 64'(dut.state_q), 64'(ST_FLUSH));
        check("br_flush2", 64'(fl_vec()), 64'h0);
        check("br_cnt", 64'(bus.flush_count), 64'd1);
        tick();
        bus.ex_mem_is_branch = 1'b0;
        #1;
        check("br_state_run", 64'(dut.state_q), 64'(ST_RUN));

        // Branch and load-use together: flush wins; load-use then stalls from FLUSH
        bus.ex_mem_is_branch = 1'b1;
        bus.id_ex_is_load = 1'b1; bus.id_ex_rd = 5'd4; bus.id_rs1 = 5'd4; bus.id_use_rs1 = 1'b1;
        #1;
        check("brlu_flush", 64'(fl_vec()), 64'h7);
        check("brlu_we", 64'(we_vec()), 64'h1f);
        tick();
        bus.ex_mem_is_branch = 1'b0;
        #1;
        check("brlu_cnt", 64'(bus.flush_count), 64'd2);
        check("brlu_stall_none", 64'(bus.stall_cycles), 64'd1);
        check("flushst_lu_we", 64'(we_vec()), 64'h07);
        check("flushst_lu_fl", 64'(fl_vec()), 64'h2);
        tick();
        idle();
        #1;
        check("flushst_lu_stall", 64'(bus.stall_cycles), 64'd2);

        // MEM wait: ready low 3 cycles then high
        bus.ex_mem_mem_req = 1'b1; bus.mem_ready = 1'b0;
        #1;
        check("mw_we_c1", 64'(we_vec()), 64'h00);
        check("mw_fl_c1", 64'(fl_vec()), 64'h0);
        tick();
        check("mw_state", 64'(dut.state_q), 64'(ST_MEM_WAIT));
        check("mw_we_c2", 64'(we_vec()), 64'h00);
        tick();
        check("mw_we_c3", 64'(we_vec()), 64'h00);
        tick();
        bus.mem_ready = 1'b1;
        #1;
        check("mw_release", 64'(we_vec()), 64'h1f);
        tick();
        idle();
        #1;
        check("mw_stall_cnt", 64'(bus.stall_cycles), 64'd5);
        check("mw_err", 64'(bus.mem_err), 64'h0);
        check("mw_state_run", 64'(dut.state_q), 64'(ST_RUN));

        // Ready on the first request cycle: no stall
        bus.ex_mem_mem_req = 1'b1; bus.mem_ready = 1'b1;
        #1;
        check("mr_now_we", 64'(we_vec()), 64'h1f);
        tick();
        idle();
        #1;
        check("mr_now_stall", 64'(bus.stall_cycles), 64'd5);

        // Timeout: ready never comes
        bus.ex_mem_mem_req = 1'b1; bus.mem_ready = 1'b0;
        n_stall = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.pc_we === 1'b0) n_stall++;
            tick();
        end
        check("to_stalled", 64'(n_stall), 64'd16);
        #1;
        check("to_release_we", 64'(we_vec()), 64'h1f);
        check("to_err_pre", 64'(bus.mem_err), 64'h0);
        tick();
        idle();
        #1;
        check("to_err", 64'(bus.mem_err), 64'h1);
        check("to_stall_cnt", 64'(bus.stall_cycles), 64'd21);
        tick();
        tick();
        check("to_err_sticky", 64'(bus.mem_err), 64'h1);

        // Reset asserted mid-MEM_WAIT
        bus.ex_mem_mem_req = 1'b1; bus.mem_ready = 1'b0;
        tick();
        tick();
        check("rw_in_wait", 64'(dut.state_q), 64'(ST_MEM_WAIT));
        #2;
        rst = 1'b0;
        idle();
        #1;
        check("rw_state", 64'(dut.state_q), 64'(ST_RUN));
        check("rw_stall", 64'(bus.stall_cycles), 64'h0);
        check("rw_flushcnt", 64'(bus.flush_count), 64'h0);
        check("rw_err", 64'(bus.mem_err), 64'h0);
        check("rw_we", 64'(we_vec()), 64'h1f);
        #3 rst = 1'b1;
        tick();
        check("post_rst_we", 64'(we_vec()), 64'h1f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
